// File: rtl/syn_fifo_fwft_if.sv
// Handshake/data bundle between a producer/consumer pair and syn_fifo_fwft.
// The master side drives writes, reads and error clear; the slave (the FIFO)
// returns read data, status flags and the fill count.
interface syn_fifo_fwft_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, data_in, rd_en, clr_err,
    input  data_out, valid, empty, full, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, clr_err,
    output data_out, valid, empty, full, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/syn_fifo_fwft.sv
// Single-clock FIFO with true full (all DEPTH entries usable), optional
// first-word-fall-through output, fill count, almost flags and sticky
// overflow/underflow error flags.
module syn_fifo_fwft #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter bit FWFT       = 1'b0,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic            clk,
  input  logic            rst,
  syn_fifo_fwft_if.slave  bus
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  // Reject configurations whose thresholds or depth cannot work.
  generate
    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
      $error("syn_fifo_fwft: DEPTH must equal 1 << ADDR_WIDTH");
    end
    if (!((AE_THRESH > 0) && (AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_bad_thresh
      $error("syn_fifo_fwft: need 0 < AE_THRESH < AF_THRESH <= DEPTH");
    end
  endgenerate

  // Storage; no reset so it maps onto block RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic             full;
  logic             empty;
  logic             wr_acc;   // write accepted this cycle
  logic             rd_acc;   // read/pop accepted this cycle (decrements count)
  logic             mem_rd;   // word moves from memory into the output register
  logic [CNT_W-1:0] mem_cnt;  // words still in memory (excludes output register)

  // Acceptance decode: who moves this cycle, derived from registered state only.
  always_comb begin
    full   = (count_q == DEPTH_C);
    empty  = FWFT ? !valid_q : (count_q == '0);
    wr_acc = bus.wr_en && !full;
    if (FWFT) begin
      // The output register holds one of the counted words while valid.
      mem_cnt = count_q - CNT_W'(valid_q);
      rd_acc  = bus.rd_en && valid_q;
      // Prefetch whenever the output register is free or being freed.
      mem_rd  = (!valid_q || rd_acc) && (mem_cnt != '0);
    end else begin
      mem_cnt = count_q;
      rd_acc  = bus.rd_en && !empty;
      mem_rd  = rd_acc;
    end
  end

  // Next-state computation for pointers, count, output register and error flags.
  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = mem_rd ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // data_out keeps its last word when nothing new is loaded.
    data_out_d = mem_rd ? mem[rd_ptr_q] : data_out_q;

    if (FWFT) begin
      if (mem_rd)      valid_d = 1'b1;
      else if (rd_acc) valid_d = 1'b0;
      else             valid_d = valid_q;
    end else begin
      valid_d = mem_rd;
    end

    // A new error event takes priority over a clear in the same cycle.
    if (bus.wr_en && full)  overflow_d = 1'b1;
    else if (bus.clr_err)   overflow_d = 1'b0;
    else                    overflow_d = overflow_q;

    if (bus.rd_en && empty) underflow_d = 1'b1;
    else if (bus.clr_err)   underflow_d = 1'b0;
    else                    underflow_d = underflow_q;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Synchronous memory write port.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.valid        = valid_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_syn_fifo_fwft.sv
// Randomised and directed bench driving a standard-mode and an FWFT-mode
// FIFO with the same stimulus, each checked against a queue-based model.
module tb_syn_fifo_fwft;
  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  syn_fifo_fwft_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bs ();
  syn_fifo_fwft_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bf ();

  syn_fifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .bus(bs)
  );
  syn_fifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .bus(bf)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Reference state: queues hold every word the FIFO is holding.
  logic [DW-1:0] q_s[$];
  logic [DW-1:0] q_f[$];
  logic [DW-1:0] exp_dout_s, exp_dout_f;
  logic          exp_valid_s, exp_valid_f;
  logic          ovf_s, udf_s, ovf_f, udf_f;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    q_s.delete();
    q_f.delete();
    exp_dout_s  = '0;
    exp_dout_f  = '0;
    exp_valid_s = 1'b0;
    exp_valid_f = 1'b0;
    ovf_s = 1'b0; udf_s = 1'b0;
    ovf_f = 1'b0; udf_f = 1'b0;
  endtask

  // One clock edge of both reference FIFOs.
  task automatic model_step(input logic wr, input logic [DW-1:0] din, input logic rd, input logic clr);
    logic s_full, s_empty, f_full, pop, nv;
    s_full  = (q_s.size() == DEPTH);
    s_empty = (q_s.size() == 0);
    ovf_s = (wr && s_full)  ? 1'b1 : (clr ? 1'b0 : ovf_s);
    udf_s = (rd && s_empty) ? 1'b1 : (clr ? 1'b0 : udf_s);
    exp_valid_s = rd && !s_empty;
    if (rd && !s_empty) exp_dout_s = q_s.pop_front();
    if (wr && !s_full) q_s.push_back(din);

    // FWFT: the head is visible once any word that was already held
    // before this edge remains after the pop.
    f_full = (q_f.size() == DEPTH);
    pop    = rd && exp_valid_f;
    ovf_f = (wr && f_full)       ? 1'b1 : (clr ? 1'b0 : ovf_f);
    udf_f = (rd && !exp_valid_f) ? 1'b1 : (clr ? 1'b0 : udf_f);
    if (pop) void'(q_f.pop_front());
    nv = (q_f.size() > 0);
    if (wr && !f_full) q_f.push_back(din);
    exp_valid_f = nv;
    if (nv) exp_dout_f = q_f[0];
  endtask

  task automatic check_outputs();
    int ns, nf;
    ns = q_s.size();
    nf = q_f.size();
    check("s.data_out", bs.data_out, exp_dout_s);
    check("s.valid",    bs.valid,    exp_valid_s);
    check("s.count",    bs.count,    64'(ns));
    check("s.empty",    bs.empty,    ns == 0);
    check("s.full",     bs.full,     ns == DEPTH);
    check("s.afull",    bs.almost_full,  ns >= AF);
    check("s.aempty",   bs.almost_empty, ns <= AE);
    check("s.ovf",      bs.overflow,  ovf_s);
    check("s.udf",      bs.underflow, udf_s);
    check("f.data_out", bf.data_out, exp_dout_f);
    check("f.valid",    bf.valid,    exp_valid_f);
    check("f.count",    bf.count,    64'(nf));
    check("f.empty",    bf.empty,    !exp_valid_f);
    check("f.full",     bf.full,     nf == DEPTH);
    check("f.afull",    bf.almost_full,  nf >= AF);
    check("f.aempty",   bf.almost_empty, nf <= AE);
    check("f.ovf",      bf.overflow,  ovf_f);
    check("f.udf",      bf.underflow, udf_f);
  endtask

  task automatic drive(input logic wr, input logic [DW-1:0] din, input logic rd, input logic clr);
    bs.wr_en = wr; bs.data_in = din; bs.rd_en = rd; bs.clr_err = clr;
    bf.wr_en = wr; bf.data_in = din; bf.rd_en = rd; bf.clr_err = clr;
  endtask

  // One transaction: drive, clock, update the model, sample 1 ns later.
  task automatic cycle(input logic wr, input logic [DW-1:0] din, input logic rd, input logic clr);
    drive(wr, din, rd, clr);
    @(posedge clk);
    model_step(wr, din, rd, clr);
    #1;
    cyc++;
    check_outputs();
    $display("cyc=%0d wr=%0b din=%h rd=%0b clr=%0b | std cnt=%0d v=%0b do=%h | fwft cnt=%0d v=%0b do=%h",
             cyc, wr, din, rd, clr, bs.count, bs.valid, bs.data_out, bf.count, bf.valid, bf.data_out);
  endtask

  task automatic rand_phase(input int n, input int wr_pct, input int rd_pct);
    for (int i = 0; i < n; i++) begin
      cycle($urandom_range(99) < wr_pct, {$urandom, $urandom},
            $urandom_range(99) < rd_pct, $urandom_range(19) == 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Fill with 0..15, then a 17th write that must be rejected.
    for (int i = 0; i < 16; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    check("fill.full",  bs.full,  1'b1);
    check("fill.count", bs.count, 64'd16);
    cycle(1'b1, 64'hDEAD, 1'b0, 1'b0);
    check("fill.ovf",   bs.overflow, 1'b1);

    // Drain all 16, then one extra read on empty.
    for (int i = 0; i < 17; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("drain.empty", bs.empty, 1'b1);
    check("drain.udf",   bs.underflow, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);          // clear alone
    cycle(1'b0, '0, 1'b1, 1'b1);          // set wins over clear
    check("err.setwins", bs.underflow, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // FWFT write-to-valid latency and pop to empty.
    cycle(1'b1, 64'hAB, 1'b0, 1'b0);
    check("fwft.lat0", bf.valid, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("fwft.lat1", bf.valid, 1'b1);
    check("fwft.data", bf.data_out, 64'hAB);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("fwft.pop",  bf.empty, 1'b1);

    // Wrap-around with the fill level held at 5.
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, DW'(200 + i), 1'b1, 1'b0);
    check("wrap.s.count", bs.count, 64'd5);
    check("wrap.f.count", bf.count, 64'd5);
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Random traffic: fill-biased, drain-biased, balanced.
    rand_phase(150, 70, 30);
    rand_phase(150, 30, 70);
    rand_phase(150, 50, 50);

    // Drain, load 9 words, then reset asynchronously with a read pending.
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b1, DW'(300 + i), 1'b0, 1'b0);
    check("pre_rst.count", bs.count, 64'd9);
    drive(1'b0, '0, 1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    drive(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rand_phase(40, 60, 40);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
